// File: rtl/column_move_reader.sv
// Consumer of a column's move FIFO: unpacks 8-slot words, skips padding, streams moves on valid/ready.
// Optional capture/promotion statistics are built when MOVE_STATS_EN is defined.
module column_move_reader #(
    parameter int SLOTS     = 8,
    parameter int MOVE_W    = 19,
    parameter int CNT_W     = 8,
    parameter int MAX_MOVES = 218
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      col_done,
    input  logic                      fifo_empty,
    output logic                      fifo_rden,
    input  logic [SLOTS*MOVE_W-1:0]   fifo_rdata,
    output logic                      move_valid,
    input  logic                      move_ready,
    output logic [MOVE_W-1:0]         move_data,
    output logic [CNT_W-1:0]          move_count,
    output logic                      list_done,
    output logic                      overflow,
    output logic [CNT_W-1:0]          capt_count,
    output logic [CNT_W-1:0]          promo_count
);
    localparam int                SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_MOVES);
    localparam logic [CNT_W-1:0]  SAT_CNT   = '1;
    localparam int                INV_BIT   = MOVE_W - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EMIT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [MOVE_W-1:0]  r_slots [SLOTS];
    logic [SLOT_W-1:0]  r_slot;
    logic [CNT_W-1:0]   r_move_count;
    logic               r_overflow;

    logic [MOVE_W-1:0]  w_cur;
    logic               w_cur_valid;
    logic               w_full;
    logic               w_present;
    logic               w_xfer;
    logic               w_advance;
    logic               w_end_word;
    logic               w_clear;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == SAT_CNT) ? v : v + CNT_W'(1);
    endfunction

    // An end-of-list word has every slot's invalid flag set.
    always_comb begin
        w_end_word = 1'b1;
        for (int k = 0; k < SLOTS; k++) begin
            w_end_word &= fifo_rdata[k*MOVE_W + INV_BIT];
        end
    end

    assign w_cur       = r_slots[r_slot];
    assign w_cur_valid = !w_cur[INV_BIT];
    assign w_full      = (r_move_count >= MAX_CNT);
    assign w_present   = (r_state == S_EMIT) && w_cur_valid && !w_full;
    assign w_xfer      = w_present && move_ready;
    assign w_advance   = (r_state == S_EMIT) && (!w_cur_valid || w_full || move_ready);
    assign w_clear     = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    assign fifo_rden  = (r_state == S_FETCH) && !fifo_empty;
    assign move_valid = w_present;
    assign move_data  = w_present ? w_cur : '0;
    assign move_count = r_move_count;
    assign list_done  = (r_state == S_DONE);
    assign overflow   = r_overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_slot       <= '0;
            r_move_count <= '0;
            r_overflow   <= 1'b0;
            for (int k = 0; k < SLOTS; k++) begin
                r_slots[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_move_count <= '0;
                        r_overflow   <= 1'b0;
                        r_state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!fifo_empty) begin
                        r_state <= S_LATCH;
                    end else if (col_done) begin
                        r_state <= S_DONE;
                    end
                end
                S_LATCH: begin
                    for (int k = 0; k < SLOTS; k++) begin
                        r_slots[k] <= fifo_rdata[k*MOVE_W +: MOVE_W];
                    end
                    r_slot  <= '0;
                    r_state <= w_end_word ? S_DONE : S_EMIT;
                end
                S_EMIT: begin
                    if (w_cur_valid && w_full) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_xfer) begin
                        r_move_count <= sat_inc(r_move_count);
                    end
                    if (w_advance) begin
                        if (r_slot == LAST_SLOT) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_slot <= r_slot + SLOT_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MOVE_STATS_EN
    localparam int CAPT_BIT  = 12;
    localparam int PROMO_BIT = MOVE_W - 2;

    logic [CNT_W-1:0] r_capt_count;
    logic [CNT_W-1:0] r_promo_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_capt_count  <= '0;
            r_promo_count <= '0;
        end else if (w_clear) begin
            r_capt_count  <= '0;
            r_promo_count <= '0;
        end else if (w_xfer) begin
            if (w_cur[CAPT_BIT]) begin
                r_capt_count <= sat_inc(r_capt_count);
            end
            if (w_cur[PROMO_BIT]) begin
                r_promo_count <= sat_inc(r_promo_count);
            end
        end
    end

    assign capt_count  = r_capt_count;
    assign promo_count = r_promo_count;
`else
    logic w_unused_clear;
    assign w_unused_clear = w_clear;
    assign capt_count     = '0;
    assign promo_count    = '0;
`endif

endmodule

// File: tb/tb_column_move_reader.sv
// Self-checking bench for column_move_reader: a queue-based FIFO plus a list-walking reference model.
module tb_column_move_reader;
    localparam int SLOTS     = 8;
    localparam int MOVE_W    = 19;
    localparam int CNT_W     = 8;
    localparam int MAX_MOVES = 218;
    localparam int WORD_W    = SLOTS * MOVE_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               col_done;
    logic               fifo_empty;
    logic               fifo_rden;
    logic [WORD_W-1:0]  fifo_rdata;
    logic               move_valid;
    logic               move_ready;
    logic [MOVE_W-1:0]  move_data;
    logic [CNT_W-1:0]   move_count;
    logic               list_done;
    logic               overflow;
    logic [CNT_W-1:0]   capt_count;
    logic [CNT_W-1:0]   promo_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WORD_W-1:0] fifo_q [$];
    logic [MOVE_W-1:0] got_q [$];
    logic [MOVE_W-1:0] exp_q [$];
    int exp_drop, exp_words, exp_capt, exp_promo;
    int rden_while_valid, rden_pulses;

    column_move_reader #(
        .SLOTS(SLOTS), .MOVE_W(MOVE_W), .CNT_W(CNT_W), .MAX_MOVES(MAX_MOVES)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .col_done(col_done),
        .fifo_empty(fifo_empty), .fifo_rden(fifo_rden), .fifo_rdata(fifo_rdata),
        .move_valid(move_valid), .move_ready(move_ready), .move_data(move_data),
        .move_count(move_count), .list_done(list_done), .overflow(overflow),
        .capt_count(capt_count), .promo_count(promo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [MOVE_W-1:0] rand_valid();
        return {1'b0, 18'($urandom)};
    endfunction

    function automatic logic [MOVE_W-1:0] rand_invalid();
        return {1'b1, 18'($urandom)};
    endfunction

    function automatic logic [WORD_W-1:0] end_word();
        logic [WORD_W-1:0] w;
        for (int s = 0; s < SLOTS; s++) w[s*MOVE_W +: MOVE_W] = rand_invalid();
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] rand_word(input int valid_pct);
        logic [WORD_W-1:0] w;
        for (int s = 0; s < SLOTS; s++)
            w[s*MOVE_W +: MOVE_W] = ($urandom_range(99) < valid_pct) ? rand_valid() : rand_invalid();
        return w;
    endfunction

    task automatic push_word(input logic [WORD_W-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Called at a falling edge: observe, let one rising edge pass, play the FIFO, return to falling edge.
    task automatic tick();
        logic pop;
        if (move_valid && move_ready) got_q.push_back(move_data);
        if (fifo_rden && move_valid) rden_while_valid++;
        if (fifo_rden) rden_pulses++;
        pop = fifo_rden;
        @(posedge clk);
        #1;
        if (pop && fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
    endtask

    // Walk the queued words as the list would be read: stop at an end word or when the FIFO runs dry.
    task automatic model_list();
        int cnt;
        logic all_inv;
        logic stop;
        logic [MOVE_W-1:0] mv;
        cnt = 0; stop = 1'b0;
        exp_q.delete(); exp_drop = 0; exp_words = 0; exp_capt = 0; exp_promo = 0;
        for (int w = 0; w < fifo_q.size() && !stop; w++) begin
            exp_words++;
            all_inv = 1'b1;
            for (int s = 0; s < SLOTS; s++) if (!fifo_q[w][s*MOVE_W + MOVE_W - 1]) all_inv = 1'b0;
            if (all_inv) begin
                stop = 1'b1;
            end else begin
                for (int s = 0; s < SLOTS; s++) begin
                    mv = fifo_q[w][s*MOVE_W +: MOVE_W];
                    if (!mv[MOVE_W-1]) begin
                        if (cnt < MAX_MOVES) begin
                            exp_q.push_back(mv);
                            cnt++;
                            exp_capt  += int'(mv[12]);
                            exp_promo += int'(mv[17]);
                        end else begin
                            exp_drop++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic do_list(input int ready_pct, input string tag);
        int cyc, rem, ecapt, epromo;
        logic bad;
        model_list();
        rem = fifo_q.size() - exp_words;
`ifdef MOVE_STATS_EN
        ecapt = exp_capt; epromo = exp_promo;
`else
        ecapt = 0; epromo = 0;
`endif
        got_q.delete(); rden_while_valid = 0;
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!list_done && cyc < 5000) begin
            move_ready = ($urandom_range(99) < ready_pct);
            tick();
            cyc++;
        end
        n_checks++;
        if (list_done !== 1'b1) begin
            n_fail++; $display("FAIL %s list_done: timeout after %0d cycles, got %b required 1", tag, cyc, list_done);
        end
        n_checks++;
        if (move_count !== CNT_W'(exp_q.size())) begin
            n_fail++; $display("FAIL %s move_count: got %0d required %0d", tag, move_count, exp_q.size());
        end
        n_checks++;
        if (overflow !== (exp_drop > 0)) begin
            n_fail++; $display("FAIL %s overflow: got %b required %b", tag, overflow, exp_drop > 0);
        end
        bad = (got_q.size() != exp_q.size());
        for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1'b1;
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL %s move_list: got %0d moves, required %0d with matching contents", tag, got_q.size(), exp_q.size());
        end
        n_checks++;
        if (fifo_q.size() != rem) begin
            n_fail++; $display("FAIL %s words_left: got %0d required %0d", tag, fifo_q.size(), rem);
        end
        n_checks++;
        if (rden_while_valid != 0) begin
            n_fail++; $display("FAIL %s rden_during_emit: got %0d required 0", tag, rden_while_valid);
        end
        n_checks++;
        if (capt_count !== CNT_W'(ecapt) || promo_count !== CNT_W'(epromo)) begin
            n_fail++; $display("FAIL %s stats: got capt=%0d promo=%0d required capt=%0d promo=%0d", tag, capt_count, promo_count, ecapt, epromo);
        end
        n_checks++;
        if (move_valid !== 1'b0 || fifo_rden !== 1'b0) begin
            n_fail++; $display("FAIL %s done_quiet: got valid=%b rden=%b required 0 0", tag, move_valid, fifo_rden);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; col_done = 1'b1; move_ready = 1'b0;
        fifo_empty = 1'b1; fifo_rdata = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({fifo_rden, move_valid, move_data, move_count, list_done, overflow, capt_count, promo_count} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got rden=%b valid=%b data=%h count=%0d done=%b ovf=%b capt=%0d promo=%0d required all 0",
                               fifo_rden, move_valid, move_data, move_count, list_done, overflow, capt_count, promo_count);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (list_done !== 1'b0 || fifo_rden !== 1'b0) begin
            n_fail++; $display("FAIL idle_quiet: got done=%b rden=%b required 0 0", list_done, fifo_rden);
        end
    endtask

    task automatic test_basic();
        logic [WORD_W-1:0] w;
        for (int s = 0; s < SLOTS; s++) w[s*MOVE_W +: MOVE_W] = rand_invalid();
        w[MOVE_W-1:0] = 19'h010A12;
        push_word(w); push_word(end_word());
        got_q.delete(); move_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        n_checks++;
        if (fifo_rden !== 1'b1) begin
            n_fail++; $display("FAIL basic_pop_cycle1: got rden=%b required 1", fifo_rden);
        end
        tick();
        n_checks++;
        if (move_valid !== 1'b0 || fifo_rden !== 1'b0) begin
            n_fail++; $display("FAIL basic_latch_cycle2: got valid=%b rden=%b required 0 0", move_valid, fifo_rden);
        end
        tick();
        n_checks++;
        if (move_valid !== 1'b1 || move_data !== 19'h010A12) begin
            n_fail++; $display("FAIL basic_first_move: got valid=%b data=%h required 1 010a12", move_valid, move_data);
        end
        for (int i = 0; i < 40 && !list_done; i++) tick();
        n_checks++;
        if (list_done !== 1'b1 || move_count !== 8'd1 || got_q.size() != 1) begin
            n_fail++; $display("FAIL basic_done: got done=%b count=%0d moves=%0d required 1 1 1", list_done, move_count, got_q.size());
        end else begin
            n_checks++;
            if (got_q[0] !== 19'h010A12) begin
                n_fail++; $display("FAIL basic_data: got %h required 010a12", got_q[0]);
            end
        end
    endtask

    task automatic test_stall();
        logic [WORD_W-1:0] w;
        logic [MOVE_W-1:0] m0, m1;
        logic bad;
        m0 = rand_valid(); m1 = rand_valid();
        for (int s = 0; s < SLOTS; s++) w[s*MOVE_W +: MOVE_W] = rand_invalid();
        w[0 +: MOVE_W] = m0; w[3*MOVE_W +: MOVE_W] = m1;
        push_word(w); push_word(end_word());
        got_q.delete(); move_ready = 1'b0; bad = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            if (move_valid !== 1'b1 || move_data !== m0 || fifo_rden !== 1'b0) bad = 1'b1;
            tick();
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL stall_hold: got valid=%b data=%h rden=%b required 1 %h 0", move_valid, move_data, fifo_rden, m0);
        end
        move_ready = 1'b1;
        tick();
        n_checks++;
        if (got_q.size() != 1 || move_count !== 8'd1) begin
            n_fail++; $display("FAIL stall_first_ready: got moves=%0d count=%0d required 1 1", got_q.size(), move_count);
        end
        for (int i = 0; i < 40 && !list_done; i++) tick();
        n_checks++;
        if (got_q.size() != 2 || move_count !== 8'd2 || list_done !== 1'b1) begin
            n_fail++; $display("FAIL stall_done: got moves=%0d count=%0d done=%b required 2 2 1", got_q.size(), move_count, list_done);
        end else begin
            n_checks++;
            if (got_q[0] !== m0 || got_q[1] !== m1) begin
                n_fail++; $display("FAIL stall_data: got %h %h required %h %h", got_q[0], got_q[1], m0, m1);
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 28; i++) push_word(rand_word(100));
        push_word(end_word());
        do_list(75, "overflow");
        n_checks++;
        if (move_count !== 8'd218 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow_limit: got count=%0d ovf=%b required 218 1", move_count, overflow);
        end
    endtask

    task automatic test_empty_done();
        fifo_q.delete(); fifo_empty = 1'b1; col_done = 1'b1; rden_pulses = 0;
        start = 1'b1; tick(); start = 1'b0;
        n_checks++;
        if (list_done !== 1'b0 || fifo_rden !== 1'b0) begin
            n_fail++; $display("FAIL empty_cycle1: got done=%b rden=%b required 0 0", list_done, fifo_rden);
        end
        tick();
        n_checks++;
        if (list_done !== 1'b1 || move_count !== 8'd0 || rden_pulses != 0) begin
            n_fail++; $display("FAIL empty_done: got done=%b count=%0d pops=%0d required 1 0 0", list_done, move_count, rden_pulses);
        end
        col_done = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (list_done !== 1'b0 || rden_pulses != 0) begin
            n_fail++; $display("FAIL empty_wait: got done=%b pops=%0d required 0 0", list_done, rden_pulses);
        end
        col_done = 1'b1;
        tick();
        n_checks++;
        if (list_done !== 1'b1) begin
            n_fail++; $display("FAIL empty_col_done: got done=%b required 1", list_done);
        end
    endtask

    task automatic test_reset_mid();
        push_word(rand_word(100)); push_word(rand_word(60)); push_word(rand_word(60)); push_word(end_word());
        move_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({fifo_rden, move_valid, move_data, move_count, list_done, overflow, capt_count, promo_count} !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got rden=%b valid=%b data=%h count=%0d done=%b required all 0",
                               fifo_rden, move_valid, move_data, move_count, list_done);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        n_checks++;
        if (fifo_q.size() != 3) begin
            n_fail++; $display("FAIL reset_mid_words: got %0d words left required 3", fifo_q.size());
        end
        do_list(80, "after_reset");
    endtask

    task automatic test_stats();
        logic [WORD_W-1:0] w;
        w[0*MOVE_W +: MOVE_W] = 19'h01000 | 19'($urandom_range(4095));
        w[1*MOVE_W +: MOVE_W] = 19'($urandom_range(4095));
        w[2*MOVE_W +: MOVE_W] = 19'h01000 | 19'($urandom_range(4095));
        w[3*MOVE_W +: MOVE_W] = rand_invalid();
        w[4*MOVE_W +: MOVE_W] = 19'h20000 | 19'($urandom_range(4095));
        w[5*MOVE_W +: MOVE_W] = 19'h01000 | 19'($urandom_range(4095));
        w[6*MOVE_W +: MOVE_W] = rand_invalid();
        w[7*MOVE_W +: MOVE_W] = 19'($urandom_range(4095));
        push_word(w); push_word(end_word());
        do_list(100, "stats");
        n_checks++;
`ifdef MOVE_STATS_EN
        if (capt_count !== 8'd3 || promo_count !== 8'd1) begin
            n_fail++; $display("FAIL stats_fixed: got capt=%0d promo=%0d required 3 1", capt_count, promo_count);
        end
`else
        if (capt_count !== 8'd0 || promo_count !== 8'd0) begin
            n_fail++; $display("FAIL stats_fixed: got capt=%0d promo=%0d required 0 0", capt_count, promo_count);
        end
`endif
    endtask

    task automatic test_random_lists();
        int nw;
        for (int l = 0; l < 6; l++) begin
            nw = $urandom_range(1, 6);
            for (int i = 0; i < nw; i++) push_word(rand_word($urandom_range(10, 90)));
            if ($urandom_range(1) == 1) push_word(end_word());
            do_list($urandom_range(30, 100), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_empty_done();
        test_reset_mid();
        test_stats();
        test_random_lists();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
